// File: rtl/ingress_rx_bridge.sv
// ingress_rx_bridge: PCIe RX AXIS to internal TLP stream bridge with FWFT FIFO, SOP/EOP framing and statistics.
// Define INGRESS_ERR_DROP_EN to drop packets whose first beat carries tuser[ERR_BIT].
module ingress_rx_bridge #(
    parameter int DATA_W     = 64,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int USER_W     = 22,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32,
    parameter int ERR_BIT    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_cnt,
    output logic                          s_axis_rx_tready,
    input  logic [DATA_W-1:0]             s_axis_rx_tdata,
    input  logic [KEEP_W-1:0]             s_axis_rx_tkeep,
    input  logic                          s_axis_rx_tlast,
    input  logic                          s_axis_rx_tvalid,
    input  logic [USER_W-1:0]             s_axis_rx_tuser,
    input  logic                          m_axis_tx_tready,
    output logic [DATA_W-1:0]             m_axis_tx_tdata,
    output logic [KEEP_W-1:0]             m_axis_tx_tkeep,
    output logic                          m_axis_tx_sop,
    output logic                          m_axis_tx_eop,
    output logic                          m_axis_tx_tvalid,
    output logic [USER_W-1:0]             m_axis_tx_tuser,
    output logic [CNT_W-1:0]              rx_packet_len,
    output logic [CNT_W-1:0]              rx_sop_cnt,
    output logic [CNT_W-1:0]              rx_eop_cnt,
    output logic [CNT_W-1:0]              rx_drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + KEEP_W + 1 + USER_W;
    localparam int PW = $clog2(KEEP_W + 1);

    typedef enum logic {IDLE, IN_PKT} out_state_e;

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              full, empty, accept, push, pop, drop_beat;
    logic [DATA_W-1:0] h_data;
    logic [KEEP_W-1:0] h_keep;
    logic              h_last;
    logic [USER_W-1:0] h_user;
    out_state_e        out_state_q, out_state_d;
    logic [PW-1:0]     pc;
    logic [CNT_W-1:0]  base, acc_q, acc_d, len_q, sop_cnt_q, eop_cnt_q;
    logic [CNT_W:0]    sum;

    assign full   = count_q == (AW+1)'(FIFO_DEPTH);
    assign empty  = count_q == '0;
    assign accept = s_axis_rx_tvalid & s_axis_rx_tready;
    assign push   = accept & ~drop_beat;
    assign pop    = m_axis_tx_tvalid & m_axis_tx_tready;

`ifdef INGRESS_ERR_DROP_EN
    typedef enum logic {PASS, DROP} in_state_e;
    in_state_e        in_state_q, in_state_d;
    logic             first_q;
    logic [CNT_W-1:0] drop_cnt_q;

    // DROP swallows the rest of a poisoned packet, so it never waits on the FIFO.
    assign s_axis_rx_tready = ~full | (in_state_q == DROP);

    always_comb begin
        in_state_d = in_state_q;
        drop_beat  = 1'b0;
        if (in_state_q == DROP) begin
            drop_beat  = s_axis_rx_tvalid;
            in_state_d = (s_axis_rx_tvalid & s_axis_rx_tlast) ? PASS : DROP;
        end else if (accept & first_q & s_axis_rx_tuser[ERR_BIT]) begin
            drop_beat  = 1'b1;
            in_state_d = s_axis_rx_tlast ? PASS : DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q <= PASS;
            first_q    <= 1'b1;
            drop_cnt_q <= '0;
        end else begin
            in_state_q <= in_state_d;
            if (accept) first_q <= s_axis_rx_tlast;
            if (clr_cnt) drop_cnt_q <= '0;
            else if (drop_beat && in_state_q == PASS) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign rx_drop_cnt = drop_cnt_q;
`else
    assign drop_beat        = 1'b0;
    assign s_axis_rx_tready = ~full;
    assign rx_drop_cnt      = '0;
`endif

    always_comb begin
        count_d = (push & ~pop) ? count_q + (AW+1)'(1) :
                  (~push & pop) ? count_q - (AW+1)'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tlast, s_axis_rx_tuser};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Head fields are gated so an empty FIFO presents all-zero outputs.
    assign {h_data, h_keep, h_last, h_user} = mem_q[rd_ptr_q];
    assign m_axis_tx_tvalid = ~empty;
    assign m_axis_tx_tdata  = empty ? '0 : h_data;
    assign m_axis_tx_tkeep  = empty ? '0 : h_keep;
    assign m_axis_tx_tuser  = empty ? '0 : h_user;
    assign m_axis_tx_eop    = ~empty & h_last;
    assign m_axis_tx_sop    = ~empty & (out_state_q == IDLE);
    assign fifo_level       = count_q;

    always_comb begin
        out_state_d = out_state_q;
        if (pop) out_state_d = m_axis_tx_eop ? IDLE : IN_PKT;
    end

    always_comb begin
        pc = '0;
        for (int i = 0; i < KEEP_W; i++) pc = pc + PW'(m_axis_tx_tkeep[i]);
        base  = m_axis_tx_sop ? '0 : acc_q;
        sum   = {1'b0, base} + (CNT_W+1)'(pc);
        acc_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_q <= IDLE;
            acc_q       <= '0;
            len_q       <= '0;
            sop_cnt_q   <= '0;
            eop_cnt_q   <= '0;
        end else begin
            out_state_q <= out_state_d;
            if (pop) acc_q <= acc_d;
            if (pop & m_axis_tx_eop) len_q <= acc_d;
            if (clr_cnt) sop_cnt_q <= '0;
            else if (pop & m_axis_tx_sop) sop_cnt_q <= sop_cnt_q + CNT_W'(1);
            if (clr_cnt) eop_cnt_q <= '0;
            else if (pop & m_axis_tx_eop) eop_cnt_q <= eop_cnt_q + CNT_W'(1);
        end
    end

    assign rx_packet_len = len_q;
    assign rx_sop_cnt    = sop_cnt_q;
    assign rx_eop_cnt    = eop_cnt_q;
endmodule

// File: tb/tb_ingress_rx_bridge.sv
// tb_ingress_rx_bridge: directed self-checking bench for ingress_rx_bridge (DATA_W=64, FIFO_DEPTH=4).
module tb_ingress_rx_bridge;
    logic        clk = 0;
    logic        rst, clr_cnt, in_valid, in_last, out_ready;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic [21:0] in_user;
    logic        s_tready, m_sop, m_eop, m_tvalid;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [21:0] m_tuser;
    logic [31:0] pkt_len, sop_cnt, eop_cnt, drop_cnt;
    logic [2:0]  level;
    int checks = 0;
    int errors = 0;

    ingress_rx_bridge dut (
        .clk(clk), .rst(rst), .clr_cnt(clr_cnt),
        .s_axis_rx_tready(s_tready), .s_axis_rx_tdata(in_data), .s_axis_rx_tkeep(in_keep),
        .s_axis_rx_tlast(in_last), .s_axis_rx_tvalid(in_valid), .s_axis_rx_tuser(in_user),
        .m_axis_tx_tready(out_ready), .m_axis_tx_tdata(m_tdata), .m_axis_tx_tkeep(m_tkeep),
        .m_axis_tx_sop(m_sop), .m_axis_tx_eop(m_eop), .m_axis_tx_tvalid(m_tvalid),
        .m_axis_tx_tuser(m_tuser), .rx_packet_len(pkt_len), .rx_sop_cnt(sop_cnt),
        .rx_eop_cnt(eop_cnt), .rx_drop_cnt(drop_cnt), .fifo_level(level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l, input logic [21:0] u);
        in_valid = v; in_data = d; in_keep = k; in_last = l; in_user = u;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %0h want 0", m_tvalid); end
        checks++; if (m_tdata !== 64'h0) begin errors++; $display("FAIL rst_tdata got %0h want 0", m_tdata); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
        checks++; if ({pkt_len, sop_cnt, eop_cnt, drop_cnt} !== 128'h0) begin errors++; $display("FAIL rst_stats got %0h want 0", {pkt_len, sop_cnt, eop_cnt, drop_cnt}); end
        rst = 0;
        tick();
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got %0b want 1", s_tready); end
    endtask

    task automatic test_single();
        out_ready = 1;
        drive(1, 64'hA1, 8'hFF, 1, 22'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if ({m_tvalid, m_sop, m_eop} !== 3'b111) begin errors++; $display("FAIL single_flags got %b want 111", {m_tvalid, m_sop, m_eop}); end
        checks++; if (m_tdata !== 64'hA1) begin errors++; $display("FAIL single_data got %0h want a1", m_tdata); end
        tick();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", m_tvalid); end
        checks++; if (pkt_len !== 32'd8) begin errors++; $display("FAIL single_len got %0d want 8", pkt_len); end
        checks++; if ({sop_cnt, eop_cnt} !== {32'd1, 32'd1}) begin errors++; $display("FAIL single_cnt got %0d/%0d want 1/1", sop_cnt, eop_cnt); end
    endtask

    task automatic test_three_beat();
        logic [63:0] d [3] = '{64'hD0, 64'hD1, 64'hD2};
        logic [7:0]  k [3] = '{8'hFF, 8'hFF, 8'h0F};
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, d[i], k[i], i == 2, 22'h0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL tb_level got %0d want 3", level); end
        for (int i = 0; i < 3; i++) begin
            out_ready = 0;
            tick();
            checks++; if (m_tdata !== d[i] || m_tkeep !== k[i]) begin errors++; $display("FAIL tb_stall_beat%0d got %0h/%0h want %0h/%0h", i, m_tdata, m_tkeep, d[i], k[i]); end
            checks++; if ({m_sop, m_eop} !== {i == 0, i == 2}) begin errors++; $display("FAIL tb_frame_beat%0d got %b want %b", i, {m_sop, m_eop}, {i == 0, i == 2}); end
            out_ready = 1;
            tick();
        end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL tb_drain got %0b want 0", m_tvalid); end
        checks++; if (pkt_len !== 32'd20) begin errors++; $display("FAIL tb_len got %0d want 20", pkt_len); end
        checks++; if ({sop_cnt, eop_cnt} !== {32'd2, 32'd2}) begin errors++; $display("FAIL tb_cnt got %0d/%0d want 2/2", sop_cnt, eop_cnt); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic acc;
        out_ready = 0;
        drive(1, 64'd100, 8'hFF, 1, 22'h0);
        for (int c = 0; c < 6; c++) begin
            acc = s_tready;
            tick();
            if (acc) begin n++; in_data = 64'd100 + 64'(n); end
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", n); end
        checks++; if (s_tready !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL bp_full got %0b/%0d want 0/4", s_tready, level); end
        checks++; if (m_tdata !== 64'd100) begin errors++; $display("FAIL bp_head got %0d want 100", m_tdata); end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++; if (s_tready !== 1'b1 || level !== 3'd3) begin errors++; $display("FAIL bp_reassert got %0b/%0d want 1/3", s_tready, level); end
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_refill got %0d want 4", level); end
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (m_tdata !== 64'(100 + i)) begin errors++; $display("FAIL bp_order%0d got %0d want %0d", i, m_tdata, 100 + i); end
            tick();
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL bp_empty got %0d want 0", level); end
    endtask

    task automatic test_clr();
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        checks++; if ({sop_cnt, eop_cnt} !== 64'h0) begin errors++; $display("FAIL clr_plain got %0d/%0d want 0/0", sop_cnt, eop_cnt); end
        out_ready = 1;
        drive(1, 64'h5, 8'hFF, 1, 22'h0);
        repeat (5) tick();
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (sop_cnt !== 32'd5) begin errors++; $display("FAIL clr_count5 got %0d want 5", sop_cnt); end
        out_ready = 0;
        drive(1, 64'h6, 8'h03, 1, 22'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        out_ready = 1;
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        checks++; if ({sop_cnt, eop_cnt} !== 64'h0) begin errors++; $display("FAIL clr_vs_inc got %0d/%0d want 0/0", sop_cnt, eop_cnt); end
        checks++; if (pkt_len !== 32'd2) begin errors++; $display("FAIL clr_len got %0d want 2", pkt_len); end
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        drive(1, 64'hB0, 8'hFF, 0, 22'h0);
        tick();
        in_data = 64'hB1;
        tick();
        drive(0, 0, 0, 0, 0);
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++; if ({m_tvalid, m_sop} !== 2'b10) begin errors++; $display("FAIL mid_inpkt got %b want 10", {m_tvalid, m_sop}); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if (m_tvalid !== 1'b0 || level !== 3'd0 || m_tdata !== 64'h0) begin errors++; $display("FAIL mid_flush got %0b/%0d/%0h want 0/0/0", m_tvalid, level, m_tdata); end
        checks++; if ({pkt_len, sop_cnt} !== 64'h0) begin errors++; $display("FAIL mid_stats got %0d/%0d want 0/0", pkt_len, sop_cnt); end
        drive(1, 64'hC0, 8'hFF, 1, 22'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if ({m_tvalid, m_sop, m_eop} !== 3'b111) begin errors++; $display("FAIL mid_newsop got %b want 111", {m_tvalid, m_sop, m_eop}); end
        out_ready = 1;
        tick();
        checks++; if (pkt_len !== 32'd8 || sop_cnt !== 32'd1) begin errors++; $display("FAIL mid_after got %0d/%0d want 8/1", pkt_len, sop_cnt); end
    endtask

    task automatic test_keep_zero();
        out_ready = 1;
        drive(1, 64'hE0, 8'h00, 0, 22'h0);
        tick();
        drive(1, 64'hE1, 8'h03, 1, 22'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (pkt_len !== 32'd2) begin errors++; $display("FAIL keep0_len got %0d want 2", pkt_len); end
        checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL keep0_drop got %0d want 0", drop_cnt); end
    endtask

`ifdef INGRESS_ERR_DROP_EN
    task automatic test_drop();
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        out_ready = 1;
        drive(1, 64'hBAD0, 8'hFF, 0, 22'h2);
        tick();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL drop_beat0 got %0b want 0", m_tvalid); end
        drive(1, 64'hBAD1, 8'hFF, 1, 22'h0);
        tick();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL drop_beat1 got %0b want 0", m_tvalid); end
        drive(1, 64'h55, 8'hFF, 1, 22'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        checks++; if ({m_tvalid, m_sop} !== 2'b11 || m_tdata !== 64'h55) begin errors++; $display("FAIL drop_good got %b/%0h want 11/55", {m_tvalid, m_sop}, m_tdata); end
        tick();
        checks++; if (drop_cnt !== 32'd1 || sop_cnt !== 32'd1) begin errors++; $display("FAIL drop_cnt got %0d/%0d want 1/1", drop_cnt, sop_cnt); end
    endtask
`endif

    initial begin
        rst = 1; clr_cnt = 0; out_ready = 0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_single();
        test_three_beat();
        test_backpressure();
        test_clr();
        test_reset_mid();
        test_keep_zero();
`ifdef INGRESS_ERR_DROP_EN
        test_drop();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
